// File: rtl/pm_pkg.sv
// Shared encodings and constants for the parking meter controller.
// Coin/preset values are kept at time width so the datapath needs no casts.
package pm_pkg;

    localparam int TIME_W = 14;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_LOW     = 2'd1,
        ST_EXPIRED = 2'd2
    } meter_state_t;

    localparam logic [TIME_W-1:0] ADD_50     = 14'd50;
    localparam logic [TIME_W-1:0] ADD_150    = 14'd150;
    localparam logic [TIME_W-1:0] ADD_200    = 14'd200;
    localparam logic [TIME_W-1:0] ADD_500    = 14'd500;
    localparam logic [TIME_W-1:0] PRESET_10  = 14'd10;
    localparam logic [TIME_W-1:0] PRESET_205 = 14'd205;

endpackage

// File: rtl/pm_tick_gen.sv
// Free-running half-second and one-second enable pulses derived from fastclk.
// Both ticks are single-cycle enables; sec_tick coincides with every other half_tick.
module pm_tick_gen #(
    parameter int HALF_DIV = 25000000
) (
    input  logic fastclk,
    input  logic rst,
    output logic half_tick,
    output logic sec_tick
);
    localparam int CW = 25;

    logic [CW-1:0] cnt;
    logic          phase;

    assign half_tick = (cnt == CW'(HALF_DIV - 1));
    assign sec_tick  = half_tick & phase;

    always_ff @(posedge fastclk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (half_tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/parking_meter_ctrl.sv
// Parking meter sequencer: coin/preset edge handling, seconds countdown,
// NORMAL/LOW/EXPIRED classification and display blink enable.
module parking_meter_ctrl
    import pm_pkg::*;
#(
    parameter int HALF_DIV   = 25000000,
    parameter int MAX_TIME   = 9999,
    parameter int LOW_THRESH = 200
) (
    input  logic              fastclk,
    input  logic              rst,
    input  logic              add_50,
    input  logic              add_150,
    input  logic              add_200,
    input  logic              add_500,
    input  logic              preset_10,
    input  logic              preset_205,
    output logic [TIME_W-1:0] time_left,
    output logic [1:0]        meter_state,
    output logic              blink_on
);
    localparam logic [TIME_W:0]   MAX_X = MAX_TIME[TIME_W:0];
    localparam logic [TIME_W-1:0] LOW_W = LOW_THRESH[TIME_W-1:0];

    logic half_tick, sec_tick;

    pm_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
        .fastclk   (fastclk),
        .rst       (rst),
        .half_tick (half_tick),
        .sec_tick  (sec_tick)
    );

    logic [5:0] btn, btn_q, rise;
    assign btn  = {preset_205, preset_10, add_500, add_200, add_150, add_50};
    assign rise = btn & ~btn_q;

    logic [TIME_W:0]   add_val, sum;
    logic [TIME_W-1:0] time_nxt;
    logic              dec;

    // Only the highest-priority edge acts; the rest are dropped this cycle.
    always_comb begin
        dec      = sec_tick && (time_left != '0);
        add_val  = '0;
        sum      = '0;
        time_nxt = time_left;
        if      (rise[3]) add_val = {1'b0, ADD_500};
        else if (rise[2]) add_val = {1'b0, ADD_200};
        else if (rise[1]) add_val = {1'b0, ADD_150};
        else if (rise[0]) add_val = {1'b0, ADD_50};
        if (rise[5]) begin
            time_nxt = PRESET_205;
        end else if (rise[4]) begin
            time_nxt = PRESET_10;
        end else if (|rise[3:0]) begin
            sum      = {1'b0, time_left} + add_val - {{TIME_W{1'b0}}, dec};
            time_nxt = (sum > MAX_X) ? MAX_X[TIME_W-1:0] : sum[TIME_W-1:0];
        end else if (dec) begin
            time_nxt = time_left - {{(TIME_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge fastclk or posedge rst) begin
        if (rst) begin
            btn_q     <= '0;
            time_left <= '0;
        end else begin
            btn_q     <= btn;
            time_left <= time_nxt;
        end
    end

    meter_state_t st, st_q;
    logic         blink_nxt;

    always_comb begin
        if (time_left == '0)       st = ST_EXPIRED;
        else if (time_left < LOW_W) st = ST_LOW;
        else                        st = ST_NORMAL;
    end
    assign meter_state = st;

    // A class change restarts the blink phase with digits visible.
    always_comb begin
        blink_nxt = blink_on;
        if (st != st_q) begin
            blink_nxt = 1'b1;
        end else begin
            case (st)
                ST_LOW:     if (sec_tick)  blink_nxt = ~blink_on;
                ST_EXPIRED: if (half_tick) blink_nxt = ~blink_on;
                default:    blink_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge fastclk or posedge rst) begin
        if (rst) begin
            st_q     <= ST_EXPIRED;
            blink_on <= 1'b1;
        end else begin
            st_q     <= st;
            blink_on <= blink_nxt;
        end
    end

endmodule

// File: tb/tb_parking_meter_ctrl.sv
// Randomized and directed bench for parking_meter_ctrl against a cycle-level
// behavioural model; literal checks pin the model at key scenario points.
module tb_parking_meter_ctrl;
    localparam int H = 4;

    logic        fastclk = 1'b0;
    logic        rst     = 1'b1;
    logic [5:0]  btn     = '0;   // {p205, p10, a500, a200, a150, a50}
    logic [13:0] time_left;
    logic [1:0]  meter_state;
    logic        blink_on;

    int tests = 0;
    int fails = 0;

    parking_meter_ctrl #(.HALF_DIV(H), .MAX_TIME(9999), .LOW_THRESH(200)) dut (
        .fastclk     (fastclk),
        .rst         (rst),
        .add_50      (btn[0]),
        .add_150     (btn[1]),
        .add_200     (btn[2]),
        .add_500     (btn[3]),
        .preset_10   (btn[4]),
        .preset_205  (btn[5]),
        .time_left   (time_left),
        .meter_state (meter_state),
        .blink_on    (blink_on)
    );

    always #5 fastclk = ~fastclk;

    // ---------------- behavioural model ----------------
    int         tl_m;
    int         cyc;
    int         ls_m;
    bit         blink_m;
    logic [5:0] pb;

    function automatic int st_of(input int t);
        if (t == 0) return 2;
        if (t < 200) return 1;
        return 0;
    endfunction

    always @(posedge fastclk or posedge rst) begin
        if (rst) begin
            tl_m = 0; cyc = 0; ls_m = 2; blink_m = 1'b1; pb = '0;
        end else begin
            bit         h, s;
            logic [5:0] e;
            int         cur, val;
            h   = (cyc % H) == H - 1;
            s   = (cyc % (2 * H)) == 2 * H - 1;
            e   = btn & ~pb;
            pb  = btn;
            cur = st_of(tl_m);
            if (cur != ls_m)          blink_m = 1'b1;
            else if (cur == 0)        blink_m = 1'b1;
            else if (cur == 1 && s)   blink_m = !blink_m;
            else if (cur == 2 && h)   blink_m = !blink_m;
            ls_m = cur;
            val = e[3] ? 500 : e[2] ? 200 : e[1] ? 150 : e[0] ? 50 : 0;
            if (e[5])          tl_m = 205;
            else if (e[4])     tl_m = 10;
            else if (val != 0) begin
                tl_m = tl_m + val - ((s && tl_m > 0) ? 1 : 0);
                if (tl_m > 9999) tl_m = 9999;
            end else if (s && tl_m > 0) tl_m = tl_m - 1;
            cyc++;
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge fastclk) begin
        if (!rst) begin
            chk("time_left", int'(time_left), tl_m);
            chk("meter_state", int'(meter_state), st_of(tl_m));
            chk("blink_on", int'(blink_on), int'(blink_m));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [5:0] m);
        @(negedge fastclk) btn = m;
        @(negedge fastclk) btn = '0;
    endtask

    // Returns on the negedge where time_left==v and, if sec_next, the next edge is a sec_tick.
    task automatic wait_for(input int v, input bit sec_next, input string n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge fastclk);
            if (tl_m == v && (!sec_next || (cyc % (2 * H)) == 2 * H - 1)) return;
        end
        fails++;
        tests++;
        $display("FAIL %s: timeout waiting for time_left=%0d", n, v);
    endtask

    initial begin
        // 1. reset and idle
        repeat (3) @(negedge fastclk);
        chk("reset time_left", int'(time_left), 0);
        chk("reset meter_state", int'(meter_state), 2);
        chk("reset blink_on", int'(blink_on), 1);
        rst = 1'b0;
        repeat (40) @(negedge fastclk);
        chk("idle time_left", int'(time_left), 0);

        // 2. preset_10 countdown to expiry
        press(6'b010000);
        chk("preset10 value", int'(time_left), 10);
        chk("preset10 LOW", int'(meter_state), 1);
        wait_for(0, 1'b0, "expire");
        @(negedge fastclk);
        chk("expire blink forced", int'(blink_on), 1);
        chk("expire state", int'(meter_state), 2);

        // 3. saturation and held button
        press(6'b100000);
        for (int i = 0; i < 20; i++) begin
            @(negedge fastclk);
            if ((cyc % (2 * H)) == 2 * H - 1) @(negedge fastclk);
            btn = 6'b001000;
            @(negedge fastclk) btn = '0;
        end
        chk("saturate 9999", int'(time_left), 9999);
        @(negedge fastclk) btn = 6'b001000;
        repeat (50) @(negedge fastclk);
        btn = '0;
        chk("hold adds once", int'(time_left >= 14'd9990 && time_left <= 14'd9999), 1);

        // 4. NORMAL -> LOW boundary
        press(6'b100000);
        wait_for(200, 1'b1, "at200");
        chk("200 NORMAL", int'(meter_state), 0);
        @(negedge fastclk);
        chk("199 value", int'(time_left), 199);
        chk("199 LOW", int'(meter_state), 1);
        repeat (40) @(negedge fastclk);

        // 5. add coincident with sec_tick; preset beats add
        press(6'b010000);
        wait_for(5, 1'b1, "at5");
        btn = 6'b000010;
        @(negedge fastclk) btn = '0;
        chk("add150 on sec_tick", int'(time_left), 154);
        press(6'b010000);
        wait_for(7, 1'b0, "at7");
        btn = 6'b101000;
        @(negedge fastclk) btn = '0;
        chk("preset205 over add500", int'(time_left), 205);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            @(negedge fastclk);
            if ($urandom_range(5) == 0) btn = btn ^ (6'b1 << $urandom_range(5));
        end
        btn = '0;

        // 6. async reset mid-countdown
        press(6'b100000);
        wait_for(123, 1'b0, "at123");
        @(posedge fastclk);
        #2 rst = 1'b1;
        #1;
        chk("async rst time_left", int'(time_left), 0);
        chk("async rst state", int'(meter_state), 2);
        chk("async rst blink", int'(blink_on), 1);
        repeat (2) @(negedge fastclk);
        rst = 1'b0;
        repeat (40) @(negedge fastclk);
        chk("post-rst idle", int'(time_left), 0);
        press(6'b000001);
        chk("post-rst coin", int'(time_left), 50);
        repeat (30) @(negedge fastclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
